// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing defaults and the coordinate type shared with the renderers.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  // Sync/enable bundle carried through the pin delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth shift register that retimes sync/enable to the renderers' RGB latency.
module sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  vga_clk,
  input  logic  reset_n,
  input  sync_t d,
  output sync_t q
);

  sync_t stage [DEPTH];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= SYNC_RST;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with registered sync/blank/pulse decode and pin-aligned delayed syncs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned PIPE_DLY  = 2
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   line_start,
  output logic   frame_start,
  output logic   hs_d,
  output logic   vs_d,
  output logic   blank_d
);

  localparam coord_t H_LAST = COORD_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST = COORD_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS  = COORD_W'(H_VISIBLE);
  localparam coord_t V_VIS  = COORD_W'(V_VISIBLE);
  localparam coord_t HS_BEG = COORD_W'(H_VISIBLE + H_FP);
  localparam coord_t HS_FIN = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = COORD_W'(V_VISIBLE + V_FP);
  localparam coord_t VS_FIN = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

  coord_t h_cnt, v_cnt;
  coord_t h_nxt, v_nxt;
  logic   h_wrap, v_wrap;
  sync_t  sync_now, sync_dly;

  // Next-state counters; status flags below decode these so they align with DrawX/DrawY.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + COORD_W'(1);
    v_nxt  = v_cnt;
    if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + COORD_W'(1);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      blank       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hs          <= !((h_nxt >= HS_BEG) && (h_nxt < HS_FIN));
      vs          <= !((v_nxt >= VS_BEG) && (v_nxt < VS_FIN));
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

  assign DrawX = h_cnt;
  assign DrawY = v_cnt;

  assign sync_now = '{hs: hs, vs: vs, blank: blank};

  sync_delay #(.DEPTH(PIPE_DLY)) u_sync_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       (sync_now),
    .q       (sync_dly)
  );

  assign hs_d    = sync_dly.hs;
  assign vs_d    = sync_dly.vs;
  assign blank_d = sync_dly.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded directed checks of vga_timing_gen: default timing plus a reduced raster at two delay depths.
module tb_vga_timing_gen;

  typedef struct {
    int          epoch;
    int          n;
    int          inst;
    logic [27:0] exp;
    logic [79:0] name;
  } vec_t;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0] dx [3];
  logic [9:0] dy [3];
  logic bl [3], hs [3], vs [3], ls [3], fs [3], hsd [3], vsd [3], bld [3];

  vec_t exp_q[$];
  int   n = 0;
  int   epoch = 0;
  int   applied = 0;
  int   miscompares = 0;

  always #20 vga_clk = ~vga_clk;

  // Edges since the latest reset release.
  always @(posedge vga_clk or negedge reset_n)
    if (!reset_n) n <= 0;
    else          n <= n + 1;

  vga_timing_gen u_def (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]),
    .blank(bl[0]), .hs(hs[0]), .vs(vs[0]), .line_start(ls[0]), .frame_start(fs[0]),
    .hs_d(hsd[0]), .vs_d(vsd[0]), .blank_d(bld[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(4)
  ) u_small4 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]),
    .blank(bl[1]), .hs(hs[1]), .vs(vs[1]), .line_start(ls[1]), .frame_start(fs[1]),
    .hs_d(hsd[1]), .vs_d(vsd[1]), .blank_d(bld[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(1)
  ) u_small1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]),
    .blank(bl[2]), .hs(hs[2]), .vs(vs[2]), .line_start(ls[2]), .frame_start(fs[2]),
    .hs_d(hsd[2]), .vs_d(vsd[2]), .blank_d(bld[2])
  );

  function automatic logic [27:0] sample(input int i);
    return {dx[i], dy[i], bl[i], hs[i], vs[i], ls[i], fs[i], hsd[i], vsd[i], bld[i]};
  endfunction

  // Flags order: {blank, hs, vs, line_start, frame_start, hs_d, vs_d, blank_d}.
  task automatic push(input int nn, input int inst, input int x, input int y,
                      input logic [7:0] f, input logic [79:0] nm);
    vec_t v;
    v.epoch = epoch;
    v.n     = nn;
    v.inst  = inst;
    v.exp   = {10'(x), 10'(y), f};
    v.name  = nm;
    exp_q.push_back(v);
  endtask

  // Monitor: every falling edge, retire all vectors due at the current cycle.
  initial begin : monitor
    vec_t        v;
    logic [27:0] act;
    forever begin
      @(negedge vga_clk);
      while (exp_q.size() > 0 &&
             (exp_q[0].epoch < epoch || (exp_q[0].epoch == epoch && exp_q[0].n <= n))) begin
        v = exp_q.pop_front();
        applied++;
        if (v.epoch != epoch || v.n != n) begin
          miscompares++;
          $display("FAIL %s inst%0d: vector for cycle %0d was never sampled (now epoch %0d cycle %0d)",
                   v.name, v.inst, v.n, epoch, n);
        end else begin
          act = sample(v.inst);
          if (act !== v.exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                     v.name, v.inst, n, act[27:18], act[17:8], act[7:0],
                     v.exp[27:18], v.exp[17:8], v.exp[7:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d vectors pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    epoch = 1;
    // Reset state and default-timing line behaviour, interleaved in cycle order.
    push(0,    0, 0,   0, 8'b11100110, "reset");
    push(0,    1, 0,   0, 8'b11100110, "reset");
    push(0,    2, 0,   0, 8'b11100110, "reset");
    push(1,    0, 1,   0, 8'b11100110, "first_edge");
    push(2,    0, 2,   0, 8'b11100111, "bd_lag2");
    push(16,   1, 16,  0, 8'b01100111, "s_blank");
    push(16,   2, 16,  0, 8'b01100111, "s_blank");
    push(18,   1, 18,  0, 8'b00100111, "s_hs_fall");
    push(18,   2, 18,  0, 8'b00100110, "s_hs_fall");
    push(19,   1, 19,  0, 8'b00100111, "s_hsd_p4");
    push(19,   2, 19,  0, 8'b00100010, "s_hsd_p1");
    push(22,   1, 22,  0, 8'b01100010, "s_hs_rise");
    push(22,   2, 22,  0, 8'b01100010, "s_hs_rise");
    push(224,  1, 24,  8, 8'b01100010, "s_pre_vs");
    push(224,  2, 24,  8, 8'b01100110, "s_pre_vs");
    push(225,  1, 0,   9, 8'b01010010, "s_vs_fall");
    push(225,  2, 0,   9, 8'b01010110, "s_vs_fall");
    push(226,  1, 1,   9, 8'b01000110, "s_vsd");
    push(226,  2, 1,   9, 8'b01000100, "s_vsd");
    push(229,  1, 4,   9, 8'b01000100, "s_vsd_p4");
    push(274,  1, 24, 10, 8'b01000000, "s_vs_end");
    push(274,  2, 24, 10, 8'b01000100, "s_vs_end");
    push(275,  1, 0,  11, 8'b01110000, "s_vs_rise");
    push(275,  2, 0,  11, 8'b01110100, "s_vs_rise");
    push(276,  1, 1,  11, 8'b01100100, "s_vsd_up");
    push(276,  2, 1,  11, 8'b01100110, "s_vsd_up");
    push(324,  1, 24, 12, 8'b01100010, "s_last");
    push(324,  2, 24, 12, 8'b01100110, "s_last");
    push(325,  1, 0,   0, 8'b11111010, "s_frame");
    push(325,  2, 0,   0, 8'b11111110, "s_frame");
    push(326,  1, 1,   0, 8'b11100110, "s_pulse_end");
    push(326,  2, 1,   0, 8'b11100111, "s_pulse_end");
    push(639,  0, 639, 0, 8'b11100111, "last_vis");
    push(640,  0, 640, 0, 8'b01100111, "blank_fall");
    push(642,  0, 642, 0, 8'b01100110, "bd_fall");
    push(649,  1, 24, 12, 8'b01100010, "s_last2");
    push(649,  2, 24, 12, 8'b01100110, "s_last2");
    push(650,  1, 0,   0, 8'b11111010, "s_frame2");
    push(650,  2, 0,   0, 8'b11111110, "s_frame2");
    push(651,  1, 1,   0, 8'b11100110, "s_frame2_end");
    push(651,  2, 1,   0, 8'b11100111, "s_frame2_end");
    push(655,  0, 655, 0, 8'b01100110, "pre_hs");
    push(656,  0, 656, 0, 8'b00100110, "hs_fall");
    push(657,  0, 657, 0, 8'b00100110, "hsd_wait");
    push(658,  0, 658, 0, 8'b00100010, "hsd_fall");
    push(712,  0, 712, 0, 8'b00100010, "hs_mid");
    push(751,  0, 751, 0, 8'b00100010, "hs_last");
    push(752,  0, 752, 0, 8'b01100010, "hs_rise");
    push(754,  0, 754, 0, 8'b01100110, "hsd_rise");
    push(799,  0, 799, 0, 8'b01100110, "line_end");
    push(800,  0, 0,   1, 8'b11110110, "line_wrap");
    push(801,  0, 1,   1, 8'b11100110, "ls_end");
    push(802,  0, 2,   1, 8'b11100111, "bd_rise");
    push(4799, 0, 799, 5, 8'b01100110, "y5_end");
    push(4800, 0, 0,   6, 8'b11110110, "y6_wrap");
    push(4801, 0, 1,   6, 8'b11100110, "y6_ls_end");
    push(5012, 0, 212, 6, 8'b11100111, "pre_reset");
    push(5012, 1, 12,  5, 8'b11100111, "pre_reset");
    push(5012, 2, 12,  5, 8'b11100111, "pre_reset");

    repeat (3) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    repeat (5012) @(posedge vga_clk);
    @(negedge vga_clk);
    // Mid-frame reset just after an edge: the next falling-edge sample must already show reset values.
    @(posedge vga_clk);
    #1 reset_n = 1'b0;
    epoch = 2;
    push(0,   0, 0,   0, 8'b11100110, "async_rst");
    push(0,   1, 0,   0, 8'b11100110, "async_rst");
    push(0,   2, 0,   0, 8'b11100110, "async_rst");
    push(1,   0, 1,   0, 8'b11100110, "rel_edge");
    push(1,   1, 1,   0, 8'b11100110, "rel_edge");
    push(1,   2, 1,   0, 8'b11100111, "rel_edge");
    push(324, 1, 24, 12, 8'b01100010, "r_last");
    push(324, 2, 24, 12, 8'b01100110, "r_last");
    push(325, 0, 325, 0, 8'b11100111, "r_def");
    push(325, 1, 0,   0, 8'b11111010, "r_frame");
    push(325, 2, 0,   0, 8'b11111110, "r_frame");

    repeat (2) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    repeat (330) @(posedge vga_clk);
    @(negedge vga_clk);
    #1;
    applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing on `vga_clk`, 25 MHz pixel clock. Produces the `DrawX`/`DrawY` pixel coordinates and the active-high `blank` display-enable that the image/sprite renderers consume. Also produces `hs`/`vs` sync copies delayed to match the renderers' ROM-plus-output-register latency, so the sync pins line up with the registered RGB. It is the stage directly upstream of every pixel-drawing module and directly drives the VGA connector sync pins.

## Interface
- `H_VISIBLE`, default 640: visible pixels per line
- `H_FP`, `H_SYNC`, `H_BP`, defaults 16, 96, 48: horizontal front porch, sync width and back porch; `H_TOTAL` = 800
- `V_VISIBLE`, default 480: visible lines
- `V_FP`, `V_SYNC`, `V_BP`, defaults 10, 2, 33: vertical front porch, sync width and back porch; `V_TOTAL` = 525
- `PIPE_DLY`, default 2: delay stages on the sync outputs; legal range 1..4
- `vga_clk` in 1: pixel clock, the only clock
- `reset_n` in 1: asynchronous, active-low reset
- `DrawX` out 10: current column, 0..H_TOTAL-1
- `DrawY` out 10: current line, 0..V_TOTAL-1
- `blank` out 1: 1 when `DrawX`<H_VISIBLE and `DrawY`<V_VISIBLE; aligned with `DrawX`/`DrawY`
- `hs`, `vs` out 1: active-low sync aligned with `DrawX`/`DrawY`
- `line_start` out 1: one-cycle pulse when `DrawX` wraps to 0
- `frame_start` out 1: one-cycle pulse when (`DrawX`,`DrawY`) wraps to (0,0)
- `hs_d`, `vs_d`, `blank_d` out 1: `hs`, `vs` and `blank` delayed by `PIPE_DLY` cycles; these drive the pins

## Operation
- Counters
  - `h_cnt` and `v_cnt` are 10 bits unsigned and are output directly as `DrawX`/`DrawY`.
  - Each cycle: if `h_cnt`==H_TOTAL-1, `h_cnt`←0 and `v_cnt` advances; otherwise `h_cnt`+1.
  - `v_cnt` advances as: if `v_cnt`==V_TOTAL-1, `v_cnt`←0; otherwise `v_cnt`+1.
  - Counters never take values ≥ H_TOTAL or ≥ V_TOTAL.
- Status outputs are registered. Each is decoded from the next-state counter values, so it is valid in the same cycle as the matching `DrawX`/`DrawY`.
  - `hs`=0 iff H_VISIBLE+H_FP ≤ x < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - `vs`=0 iff V_VISIBLE+V_FP ≤ y < V_VISIBLE+V_FP+V_SYNC, i.e. lines 490..491, for whole lines.
  - `blank` follows the visible-region rule in Interface.
  - `line_start`=1 iff next x==0 following a wrap.
  - `frame_start`=1 iff next (x,y)==(0,0) following a wrap.
- Delay line: `PIPE_DLY`-deep shift register on {`hs`,`vs`,`blank`}, yielding {`hs_d`,`vs_d`,`blank_d`}.
- Reset, asynchronous on the falling edge of `reset_n`:
  - `DrawX`=0, `DrawY`=0.
  - `blank`=1, matching (0,0) being visible.
  - `hs`=1, `vs`=1.
  - `line_start`=0, `frame_start`=0. The first frame after reset is not flagged; the first pulse is at the first wrap.
  - All delay stages = {1,1,0}, so `hs_d`=1, `vs_d`=1, `blank_d`=0.
- Release: counting starts on the first `vga_clk` rising edge with `reset_n`=1.
- Reset mid-frame aborts the frame immediately. No partial-line recovery is required.

## Timing
- The first edge after reset release gives `DrawX`=1.
- Line period is 800 cycles; frame period is 420 000 cycles.
- `hs` low for 96 consecutive cycles per line; `vs` low for 1600 consecutive cycles per frame.
- `blank` high for 640 cycles per visible line; 307 200 `blank`-high cycles per frame.
- `*_d` outputs lag the aligned outputs by exactly `PIPE_DLY` edges. The default of 2 matches the 1-cycle ROM read plus 1-cycle RGB register downstream.
- Simultaneous horizontal and vertical wrap at (799,524) gives (0,0), with `line_start` and `frame_start` both high in that cycle.

## Structure
- Package `vga_pkg`:
  - Default timing constants and derived `H_TOTAL`, `V_TOTAL`, `HS_START`, `HS_END`, `VS_START`, `VS_END`.
  - 10-bit `coord_t` typedef, shared with the renderers.
- Sub-module `sync_delay`: parameterised-depth shift register with reset value {1,1,0}, instantiated once.

## Test plan
- Assert `reset_n`=0 at any point → outputs immediately (0,0,blank=1,hs=1,vs=1,pulses 0,hs_d=1,vs_d=1,blank_d=0); the next edge after release → `DrawX`=1.
- Run one line → `hs` falls as `DrawX` becomes 656 and rises at 752; `blank` falls at 640.
- Line wrap: after `DrawX`=799, `DrawY`=5 → next cycle (0,6) with `line_start`=1 for exactly one cycle.
- Frame wrap: (799,524) → (0,0) with both pulses; consecutive `frame_start` pulses are exactly 420 000 cycles apart; `vs` low for lines 490–491 only.
- Delay check, `PIPE_DLY`=2: `hs_d` falls exactly 2 edges after `hs`; repeat with `PIPE_DLY`=1 and 4.
- Reset pulse at (300,200) → immediate (0,0); the next `frame_start` occurs 420 000 cycles after release.
